sdram_pattern_tester: RTL and testbench
=======================================

# sdram_pattern_tester

Parametrised SDRAM read/write self-test master, the successor to the fixed 10-word seven-segment write/read test. On a start request it writes `NUM_WORDS` words of a selectable data pattern from `BASE_ADDR` through an Avalon-style master port that honours `iWaitrequest`. It then reads every word back, compares each against the regenerated pattern and reports pass/fail, the error count and the first failing address. It sits between the board button/LED logic and the SDRAM controller's master port.

## Interface
- `ADDR_W`, 25, address width
- `DATA_W`, 16, data width (≥ 8)
- `NUM_WORDS`, 10, words per run (1 .. 2^ADDR_W − BASE_ADDR)
- `BASE_ADDR`, 0, first word address
- `TIMEOUT`, 8_000_000, max cycles waiting for one read's data

Ports:
- `iCLK` in 1: single clock; all logic is on its rising edge
- `iRST_n` in 1: reset, asynchronous, active-low
- `iSTART` in 1: asynchronous level; the rising edge starts a run
- `iMODE` in 2: pattern select, sampled on start
- `oAddress` out ADDR_W: word address for write and read
- `oWrite` out 1: write request
- `oWritedata` out DATA_W: write data
- `oRead` out 1: read request
- `iWaitrequest` in 1: slave stall; a request is accepted in a cycle where the request is high and `iWaitrequest` is low
- `iReaddata` in DATA_W: read data
- `iReaddatavalid` in 1: `iReaddata` is valid this cycle
- `oBusy` out 1: a run is in progress
- `oDone` out 1: the last run finished
- `oPass` out 1: the last run finished with zero errors
- `oTimeout` out 1: at least one read timed out in the last run
- `oErr_cnt` out 16: mismatch plus timeout count, saturates at 16'hFFFF
- `oFirst_err_addr` out ADDR_W: address of the first error, 0 if none

## Operation
- Pattern `P(i)`, where i is the word index 0..NUM_WORDS−1, zero-extended to DATA_W:
  - mode 0: seven-segment code of `i mod 10`. Codes 0..9 are 40,79,24,30,19,12,02,78,00,10 (hex, 7 bits).
  - mode 1: `i[DATA_W-1:0]`
  - mode 2: `1 << (i mod DATA_W)`
  - mode 3: `~i[DATA_W-1:0]`
- `iSTART` path:
  - Passes through a 2-flop synchroniser.
  - rise = sync2 & ~prev.
  - A rise is honoured only in IDLE or DONE; otherwise it is ignored.
- FSM states:
  - IDLE → WRITE on rise. On this transition: capture `iMODE`; clear i, `oErr_cnt`, `oFirst_err_addr`, `oTimeout`, `oDone` and `oPass`.
  - WRITE:
    - Drive `oWrite`=1, `oAddress`=BASE_ADDR+i, `oWritedata`=P(i).
    - All three are held stable while `iWaitrequest`=1.
    - On accept: i++. On accepting the last word: i←0 and go to RD_REQ.
  - RD_REQ:
    - Drive `oRead`=1, `oAddress`=BASE_ADDR+i, held while stalled.
    - On accept go to RD_WAIT and clear the timeout counter.
  - RD_WAIT: `oRead`=0; the timeout counter increments each cycle.
    - On `iReaddatavalid`: if `iReaddata`≠P(i), it is an error.
    - If the counter reaches TIMEOUT−1 with no valid data, it is an error and `oTimeout`←1.
    - Either way: if this was the last word go to DONE, otherwise i++ and go to RD_REQ.
  - DONE: `oDone`=1, `oPass`=(`oErr_cnt`==0). Stay until rise, then behave as IDLE→WRITE.
- Error handling:
  - On the first error of a run, `oFirst_err_addr`←BASE_ADDR+i.
  - `oErr_cnt` increments on every error, with saturation.
- One read is outstanding at a time. `iReaddatavalid` outside RD_WAIT is ignored and counts nothing.
- `oBusy`=1 in WRITE, RD_REQ and RD_WAIT.
- Address arithmetic is ADDR_W bits, modulo 2^ADDR_W.

## Timing
- Reset value of every output and register: 0. State is IDLE.
- Reset mid-run aborts immediately: requests drop asynchronously and no result is kept.
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- Start latency: `iSTART` first sampled high at edge e0 → `oWrite`=1 after edge e2.
- With `iWaitrequest`=0:
  - Writes take 1 word/cycle, so the write phase lasts NUM_WORDS cycles.
  - Each read takes 1 cycle (RD_REQ) plus (L+1) cycles, where L is the cycles from accept to `iReaddatavalid`.
- `oWrite`=0 in the cycle the FSM enters RD_REQ. `oWrite` and `oRead` are never both high.
- `oDone` and `oPass` rise one cycle after the final valid data or timeout.
- Data arriving in the same cycle the counter reaches TIMEOUT−1 counts as data, not as a timeout.

## Test plan
- Mode 0, NUM_WORDS=10, ideal memory (no wait, L=1):
  - writes go to addresses 0..9 with data 0040,0079,…,0010
  - `oDone`=1, `oPass`=1, `oErr_cnt`=0.
- Mode 2, DATA_W=16, NUM_WORDS=20, with `iWaitrequest` high for 3 cycles on every request:
  - address and data are held through each stall
  - word 17 is written as 0x0002
  - the run passes.
- Memory corrupts the words at addresses 3 and 7 (bit 0 flipped):
  - `oErr_cnt`=2, `oFirst_err_addr`=3, `oPass`=0, `oTimeout`=0.
- TIMEOUT=16, memory never returns `iReaddatavalid` for address 5:
  - RD_WAIT lasts exactly 16 cycles for that word
  - `oTimeout`=1, `oErr_cnt`=1, `oFirst_err_addr`=5, and the remaining reads still occur.
- `iSTART` re-pulsed during the write phase:
  - ignored, and the run completes normally.
- Start pulse in DONE:
  - counters clear and a new run begins with the newly sampled `iMODE`.
- `iRST_n` asserted mid-read:
  - all outputs are 0 immediately
  - after release the block stays in IDLE until the next `iSTART` rise.

Source files
------------

// File: rtl/sdram_pattern_tester.sv
// SDRAM self-test master: writes NUM_WORDS pattern words from BASE_ADDR, reads them back,
// compares against the regenerated pattern and reports pass/fail, error count and first failing address.
module sdram_pattern_tester #(
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned NUM_WORDS = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned TIMEOUT   = 8_000_000
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iSTART,
  input  logic [1:0]        iMODE,
  output logic [ADDR_W-1:0] oAddress,
  output logic              oWrite,
  output logic [DATA_W-1:0] oWritedata,
  output logic              oRead,
  input  logic              iWaitrequest,
  input  logic [DATA_W-1:0] iReaddata,
  input  logic              iReaddatavalid,
  output logic              oBusy,
  output logic              oDone,
  output logic              oPass,
  output logic              oTimeout,
  output logic [15:0]       oErr_cnt,
  output logic [ADDR_W-1:0] oFirst_err_addr
);

  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned EXT_W = IDX_W + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RD_REQ, S_RD_WAIT, S_DONE
  } state_t;

  state_t             r_state, w_next;
  logic               r_sync1, r_sync2, r_prev;
  logic [1:0]         r_mode;
  logic [IDX_W-1:0]   r_idx;
  logic [3:0]         r_seg;
  logic [BIT_W-1:0]   r_bit;
  logic [TO_W-1:0]    r_to_cnt;
  logic [15:0]        r_err_cnt;
  logic [ADDR_W-1:0]  r_first_err;
  logic               r_timeout, r_done, r_pass;

  logic               w_rise, w_start, w_last, w_wr_acc, w_rd_acc, w_to_hit, w_mis, w_err;
  logic               w_rd_end, w_adv, w_clr_idx;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_pat;
  logic [EXT_W-1:0]   w_idx_ext;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign w_rise    = r_sync2 & ~r_prev;
  assign w_start   = w_rise && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last    = (r_idx == IDX_W'(NUM_WORDS - 1));
  assign w_wr_acc  = (r_state == S_WRITE) && !iWaitrequest;
  assign w_rd_acc  = (r_state == S_RD_REQ) && !iWaitrequest;
  assign w_mis     = (r_state == S_RD_WAIT) && iReaddatavalid && (iReaddata != w_pat);
  assign w_to_hit  = (r_state == S_RD_WAIT) && !iReaddatavalid && (r_to_cnt == TO_W'(TIMEOUT - 1));
  assign w_err     = w_mis || w_to_hit;
  assign w_rd_end  = (r_state == S_RD_WAIT) && (iReaddatavalid || w_to_hit);
  assign w_adv     = ((w_wr_acc || w_rd_end) && !w_last);
  assign w_clr_idx = w_start || (w_wr_acc && w_last);
  assign w_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'(r_idx);

  // Pattern for the current word; seg/bit counters track i mod 10 and i mod DATA_W
  always_comb begin
    w_idx_ext = EXT_W'(r_idx);
    case (r_mode)
      2'd0:    w_pat = DATA_W'(seg7(r_seg));
      2'd1:    w_pat = w_idx_ext[DATA_W-1:0];
      2'd2:    w_pat = DATA_W'(1) << r_bit;
      default: w_pat = ~w_idx_ext[DATA_W-1:0];
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= iSTART;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_rise) w_next = S_WRITE;
      S_WRITE:        if (w_wr_acc && w_last) w_next = S_RD_REQ;
      S_RD_REQ:       if (w_rd_acc) w_next = S_RD_WAIT;
      S_RD_WAIT:      if (w_rd_end) w_next = w_last ? S_DONE : S_RD_REQ;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_mode      <= 2'd0;
      r_idx       <= '0;
      r_seg       <= 4'd0;
      r_bit       <= '0;
      r_to_cnt    <= '0;
      r_err_cnt   <= 16'd0;
      r_first_err <= '0;
      r_timeout   <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      if (w_clr_idx) begin
        r_idx <= '0;
        r_seg <= 4'd0;
        r_bit <= '0;
      end else if (w_adv) begin
        r_idx <= r_idx + IDX_W'(1);
        r_seg <= (r_seg == 4'd9) ? 4'd0 : r_seg + 4'd1;
        r_bit <= (r_bit == BIT_W'(DATA_W - 1)) ? '0 : r_bit + BIT_W'(1);
      end
      if (w_rd_acc) r_to_cnt <= '0;
      else if (r_state == S_RD_WAIT) r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_start) begin
        r_mode      <= iMODE;
        r_err_cnt   <= 16'd0;
        r_first_err <= '0;
        r_timeout   <= 1'b0;
        r_done      <= 1'b0;
        r_pass      <= 1'b0;
      end else begin
        // A zero count means no earlier error this run; saturation never returns to zero
        if (w_err) begin
          if (r_err_cnt == 16'd0) r_first_err <= w_addr;
          if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        end
        if (w_to_hit) r_timeout <= 1'b1;
        if (w_rd_end && w_last) begin
          r_done <= 1'b1;
          r_pass <= (r_err_cnt == 16'd0) && !w_err;
        end
      end
    end
  end

  assign oWrite          = (r_state == S_WRITE);
  assign oRead           = (r_state == S_RD_REQ);
  assign oBusy           = (r_state == S_WRITE) || (r_state == S_RD_REQ) || (r_state == S_RD_WAIT);
  assign oAddress        = (oWrite || oRead) ? w_addr : '0;
  assign oWritedata      = oWrite ? w_pat : '0;
  assign oDone           = r_done;
  assign oPass           = r_pass;
  assign oTimeout        = r_timeout;
  assign oErr_cnt        = r_err_cnt;
  assign oFirst_err_addr = r_first_err;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester: behavioural SDRAM slave with stall, corruption and
// dropped-read knobs; expected values are hand-computed constants.
module tb_sdram_pattern_tester;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iSTART = 1'b0;
  logic [1:0]  iMODE = 2'd0;
  logic [24:0] oAddress;
  logic        oWrite;
  logic [15:0] oWritedata;
  logic        oRead;
  logic        iWaitrequest = 1'b0;
  logic [15:0] iReaddata = 16'd0;
  logic        iReaddatavalid = 1'b0;
  logic        oBusy, oDone, oPass, oTimeout;
  logic [15:0] oErr_cnt;
  logic [24:0] oFirst_err_addr;

  sdram_pattern_tester #(
    .ADDR_W(25), .DATA_W(16), .NUM_WORDS(20), .BASE_ADDR(0), .TIMEOUT(16)
  ) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iSTART(iSTART), .iMODE(iMODE),
    .oAddress(oAddress), .oWrite(oWrite), .oWritedata(oWritedata), .oRead(oRead),
    .iWaitrequest(iWaitrequest), .iReaddata(iReaddata), .iReaddatavalid(iReaddatavalid),
    .oBusy(oBusy), .oDone(oDone), .oPass(oPass), .oTimeout(oTimeout),
    .oErr_cnt(oErr_cnt), .oFirst_err_addr(oFirst_err_addr)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave model knobs (written only by the stimulus process)
  int wait_n    = 0;
  int bad_a0    = 63;
  int bad_a1    = 63;
  int drop_addr = 63;

  // Slave model state and logs (written only by the slave process)
  logic [15:0] mem [64];
  logic [24:0] wr_addr_log [512];
  logic [15:0] wr_data_log [512];
  int wr_n = 0, rd_n = 0, hold_bad = 0, stalls = 0, overlap = 0, drop_len = 0;
  int stall = 0, rd_a = 0;
  bit pend = 0, drop_on = 0;
  logic [24:0] hold_a;
  logic [15:0] hold_d;

  // Decisions for the next rising edge are made on the falling edge
  always @(negedge iCLK) begin
    if (!iRST_n) begin
      iWaitrequest = 1'b0; iReaddatavalid = 1'b0; iReaddata = 16'd0;
      pend = 0; stall = 0; drop_on = 0;
    end else begin
      iReaddatavalid = 1'b0;
      iReaddata = 16'd0;
      if (pend) begin
        pend = 0;
        if (rd_a != drop_addr) begin
          iReaddatavalid = 1'b1;
          iReaddata = mem[rd_a] ^ ((rd_a == bad_a0 || rd_a == bad_a1) ? 16'h0001 : 16'h0000);
        end
      end
      if (oWrite && oRead) overlap++;
      if (drop_on) begin
        if (oBusy && !oWrite && !oRead) drop_len++;
        else drop_on = 0;
      end
      if (oWrite || oRead) begin
        if (stall == 0) begin
          hold_a = oAddress; hold_d = oWritedata;
        end else if (oAddress !== hold_a || oWritedata !== hold_d) hold_bad++;
        if (stall < wait_n) begin
          iWaitrequest = 1'b1; stall++; stalls++;
        end else begin
          iWaitrequest = 1'b0; stall = 0;
          if (oWrite) begin
            mem[oAddress[5:0]] = oWritedata;
            wr_addr_log[wr_n] = oAddress;
            wr_data_log[wr_n] = oWritedata;
            wr_n++;
          end else begin
            rd_a = int'(oAddress[5:0]);
            pend = 1; rd_n++;
            if (rd_a == drop_addr) begin drop_on = 1; drop_len = 0; end
          end
        end
      end else begin
        iWaitrequest = 1'b0; stall = 0;
      end
    end
  end

  task automatic start_run(input logic [1:0] mode);
    @(negedge iCLK);
    iMODE = mode; iSTART = 1'b1;
    repeat (3) @(negedge iCLK);
    iSTART = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!oDone && n < 3000) begin @(negedge iCLK); n++; end
    check({tag, "_done"}, 32'(oDone), 32'd1);
  endtask

  logic [15:0] seg_tab [10];
  int wb, rb, hb, sb;

  initial begin
    seg_tab = '{16'h0040, 16'h0079, 16'h0024, 16'h0030, 16'h0019,
                16'h0012, 16'h0002, 16'h0078, 16'h0000, 16'h0010};
    repeat (3) @(negedge iCLK);
    check("rst_write", 32'(oWrite), 0);
    check("rst_read", 32'(oRead), 0);
    check("rst_busy", 32'(oBusy), 0);
    check("rst_done", 32'(oDone), 0);
    check("rst_addr", 32'(oAddress), 0);
    check("rst_wdata", 32'(oWritedata), 0);
    check("rst_errcnt", 32'(oErr_cnt), 0);
    iRST_n = 1'b1;
    repeat (2) @(negedge iCLK);

    // Run A: mode 0, ideal memory, start latency
    wb = wr_n; rb = rd_n;
    iMODE = 2'd0; iSTART = 1'b1;
    @(negedge iCLK); check("lat_e0", 32'(oWrite), 0);
    @(negedge iCLK); check("lat_e1", 32'(oWrite), 0);
    @(negedge iCLK); check("lat_e2", 32'(oWrite), 1);
    check("lat_addr", 32'(oAddress), 0);
    check("lat_data", 32'(oWritedata), 32'h0040);
    iSTART = 1'b0;
    wait_done("A");
    check("A_wr_n", 32'(wr_n - wb), 20);
    check("A_rd_n", 32'(rd_n - rb), 20);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("A_waddr%0d", i), 32'(wr_addr_log[wb + i]), 32'(i));
      check($sformatf("A_wdata%0d", i), 32'(wr_data_log[wb + i]), 32'(seg_tab[i % 10]));
    end
    check("A_pass", 32'(oPass), 1);
    check("A_err", 32'(oErr_cnt), 0);
    check("A_to", 32'(oTimeout), 0);
    check("A_busy", 32'(oBusy), 0);

    // Run C: mode 1, addresses 3 and 7 read back with bit 0 flipped
    bad_a0 = 3; bad_a1 = 7;
    wb = wr_n;
    start_run(2'd1);
    check("C_done_clr", 32'(oDone), 0);
    wait_done("C");
    check("C_wdata5", 32'(wr_data_log[wb + 5]), 32'h0005);
    check("C_wdata19", 32'(wr_data_log[wb + 19]), 32'h0013);
    check("C_err", 32'(oErr_cnt), 2);
    check("C_first", 32'(oFirst_err_addr), 3);
    check("C_pass", 32'(oPass), 0);
    check("C_to", 32'(oTimeout), 0);
    bad_a0 = 63; bad_a1 = 63;

    // Run B: from DONE, mode 2, 3-cycle stalls, start re-pulsed mid-write
    wait_n = 3;
    wb = wr_n; rb = rd_n; hb = hold_bad; sb = stalls;
    start_run(2'd2);
    repeat (10) @(negedge iCLK);
    check("B_rewrite_busy", 32'(oWrite), 1);
    iSTART = 1'b1;
    repeat (3) @(negedge iCLK);
    iSTART = 1'b0;
    wait_done("B");
    check("B_wr_n", 32'(wr_n - wb), 20);
    check("B_rd_n", 32'(rd_n - rb), 20);
    check("B_stalled", 32'(stalls - sb > 100), 1);
    check("B_hold", 32'(hold_bad - hb), 0);
    check("B_wdata0", 32'(wr_data_log[wb + 0]), 32'h0001);
    check("B_wdata15", 32'(wr_data_log[wb + 15]), 32'h8000);
    check("B_wdata17", 32'(wr_data_log[wb + 17]), 32'h0002);
    check("B_waddr17", 32'(wr_addr_log[wb + 17]), 17);
    check("B_pass", 32'(oPass), 1);
    check("B_err", 32'(oErr_cnt), 0);
    check("B_first", 32'(oFirst_err_addr), 0);
    wait_n = 0;

    // Run D: mode 3, address 5 never answers
    drop_addr = 5;
    wb = wr_n; rb = rd_n;
    start_run(2'd3);
    wait_done("D");
    check("D_wdata0", 32'(wr_data_log[wb + 0]), 32'h0000FFFF);
    check("D_wdata5", 32'(wr_data_log[wb + 5]), 32'h0000FFFA);
    check("D_rdwait_len", 32'(drop_len), 16);
    check("D_rd_n", 32'(rd_n - rb), 20);
    check("D_to", 32'(oTimeout), 1);
    check("D_err", 32'(oErr_cnt), 1);
    check("D_first", 32'(oFirst_err_addr), 5);
    check("D_pass", 32'(oPass), 0);
    drop_addr = 63;

    // Reset in the middle of the read phase
    start_run(2'd1);
    begin
      int n = 0;
      while (!oRead && n < 500) begin @(negedge iCLK); n++; end
      check("R_saw_read", 32'(oRead), 1);
    end
    iRST_n = 1'b0;
    #1;
    check("R_read", 32'(oRead), 0);
    check("R_busy", 32'(oBusy), 0);
    check("R_addr", 32'(oAddress), 0);
    check("R_to", 32'(oTimeout), 0);
    check("R_errcnt", 32'(oErr_cnt), 0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    wb = wr_n;
    repeat (10) @(negedge iCLK);
    check("R_idle_busy", 32'(oBusy), 0);
    check("R_idle_wr", 32'(wr_n - wb), 0);
    check("R_idle_done", 32'(oDone), 0);
    start_run(2'd0);
    wait_done("R2");
    check("R2_pass", 32'(oPass), 1);
    check("R2_wr_n", 32'(wr_n - wb), 20);
    check("overlap", 32'(overlap), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
